// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
// This block arbitrates two pixel writers into the single VGA frame-buffer write port.
// Requester 0 is the board drawer and requester 1 is the cursor/overlay drawer.
//   - Round-robin grant with a one-cycle arbitration bubble from IDLE.
//   - When one requester releases its grant, the other valid requester takes over with no bubble.
//   - A grant is limited to MAX_BURST beats.
//   - Each accepted beat appears on the registered write port exactly one cycle later.
// Optional feature: define FBWA_ADDR_CHECK_EN to drop beats whose address is >= MEM_SIZE
// and to count those beats in drop_cnt. Without the macro, drop_cnt reads as zero.
module fb_write_arbiter #(
  parameter logic [15:0] MEM_SIZE  = 16'd19200,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  input  logic [14:0] r0_addr,
  input  logic [23:0] r0_data,
  output logic        r0_ready,
  input  logic        r1_valid,
  input  logic [14:0] r1_addr,
  input  logic [23:0] r1_data,
  output logic        r1_ready,
  output logic [14:0] wr_addr,
  output logic [23:0] wr_data,
  output logic        wr_en,
  output logic [1:0]  owner,
  output logic [15:0] drop_cnt
);

  // The state encoding equals the owner encoding, so owner is the state register itself.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  // Reject parameter values the datapath cannot represent.
  if ((MAX_BURST < 1) || (MAX_BURST > 255)) begin : g_bad_burst
    $error("fb_write_arbiter: MAX_BURST must be in 1..255");
  end
  if ((MEM_SIZE == 16'd0) || (MEM_SIZE > 16'd32768)) begin : g_bad_mem
    $error("fb_write_arbiter: MEM_SIZE must be in 1..32768 for a 15-bit address");
  end

  state_t      state_r;
  state_t      state_next_s;
  logic        last_owner_r;       // 0: requester 0 was served last, 1: requester 1
  logic        last_owner_next_s;
  logic [7:0]  beat_cnt_r;
  logic        beat_last_s;
  logic        grant_entry_s;
  logic        accept_s;
  logic [14:0] sel_addr_s;
  logic [23:0] sel_data_s;
  logic        in_range_s;
  logic        forward_s;
  logic        wr_en_r;
  logic [14:0] wr_addr_r;
  logic [23:0] wr_data_r;

  assign owner   = state_r;
  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;

  // The beat being accepted now is the last one this grant may take.
  assign beat_last_s   = ((beat_cnt_r + 8'd1) == MAX_BURST_C);
  // Entering any grant state, including a direct handoff, starts a fresh burst count.
  assign grant_entry_s = (state_next_s != state_r) && (state_next_s != IDLE);

  // State register and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      last_owner_r <= 1'b1;
    end else begin
      state_r      <= state_next_s;
      last_owner_r <= last_owner_next_s;
    end
  end

  // Next-state logic: arbitrate from IDLE, and release a grant on a dropped valid or on burst end.
  always_comb begin
    state_next_s      = state_r;
    last_owner_next_s = last_owner_r;
    case (state_r)
      IDLE: begin
        if (r0_valid && r1_valid) begin
          state_next_s = last_owner_r ? GRANT0 : GRANT1;
        end else if (r0_valid) begin
          state_next_s = GRANT0;
        end else if (r1_valid) begin
          state_next_s = GRANT1;
        end else begin
          state_next_s = IDLE;
        end
      end
      GRANT0: begin
        if (!r0_valid || beat_last_s) begin
          last_owner_next_s = 1'b0;
          state_next_s      = r1_valid ? GRANT1 : IDLE;
        end else begin
          state_next_s = GRANT0;
        end
      end
      GRANT1: begin
        if (!r1_valid || beat_last_s) begin
          last_owner_next_s = 1'b1;
          state_next_s      = r0_valid ? GRANT0 : IDLE;
        end else begin
          state_next_s = GRANT1;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output decode: ready and the write mux depend only on the state, so at most one ready can be high.
  always_comb begin
    r0_ready   = 1'b0;
    r1_ready   = 1'b0;
    accept_s   = 1'b0;
    sel_addr_s = 15'd0;
    sel_data_s = 24'd0;
    case (state_r)
      GRANT0: begin
        r0_ready   = 1'b1;
        accept_s   = r0_valid;
        sel_addr_s = r0_addr;
        sel_data_s = r0_data;
      end
      GRANT1: begin
        r1_ready   = 1'b1;
        accept_s   = r1_valid;
        sel_addr_s = r1_addr;
        sel_data_s = r1_data;
      end
      default: begin
        r0_ready   = 1'b0;
        r1_ready   = 1'b0;
        accept_s   = 1'b0;
        sel_addr_s = 15'd0;
        sel_data_s = 24'd0;
      end
    endcase
  end

  // Beat counter for the grant currently held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_r <= 8'd0;
    end else if (grant_entry_s) begin
      beat_cnt_r <= 8'd0;
    end else if (accept_s) begin
      beat_cnt_r <= beat_cnt_r + 8'd1;
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

`ifdef FBWA_ADDR_CHECK_EN
  logic [15:0] drop_cnt_r;

  assign in_range_s = ({1'b0, sel_addr_s} < MEM_SIZE);
  assign drop_cnt   = drop_cnt_r;

  // Count consumed out-of-range beats, saturating at the counter maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= 16'd0;
    end else if (accept_s && !in_range_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end
`else
  assign in_range_s = 1'b1;
  assign drop_cnt   = 16'd0;
`endif

  // A beat is still consumed when it is dropped; only in-range beats reach the memory.
  assign forward_s = accept_s && in_range_s;

  // Registered write port: strobe one cycle after acceptance, address/data held between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= 15'd0;
      wr_data_r <= 24'd0;
    end else if (forward_s) begin
      wr_en_r   <= 1'b1;
      wr_addr_r <= sel_addr_s;
      wr_data_r <= sel_data_s;
    end else begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= wr_addr_r;
      wr_data_r <= wr_data_r;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter (built with MAX_BURST=4).
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_valid = 1'b0;
  logic [14:0] r0_addr = 15'd0;
  logic [23:0] r0_data = 24'd0;
  logic        r0_ready;
  logic        r1_valid = 1'b0;
  logic [14:0] r1_addr = 15'd0;
  logic [23:0] r1_data = 24'd0;
  logic        r1_ready;
  logic [14:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_en;
  logic [1:0]  owner;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_write_arbiter #(.MEM_SIZE(16'd19200), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(r1_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .owner(owner), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic        rst;
    logic        v0;
    logic [14:0] a0;
    logic [23:0] d0;
    logic        v1;
    logic [14:0] a1;
    logic [23:0] d1;
    logic [1:0]  e_owner;
    logic        e_r0r;
    logic        e_r1r;
    logic        e_wen;
    logic [14:0] e_waddr;
    logic [23:0] e_wdata;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic r, input logic v0, input logic [14:0] a0, input logic [23:0] d0,
                              input logic v1, input logic [14:0] a1, input logic [23:0] d1,
                              input logic [1:0] eo, input logic e0, input logic e1, input logic ew,
                              input logic [14:0] ea, input logic [23:0] ed);
    vec_t v;
    v.rst = r; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.e_owner = eo; v.e_r0r = e0; v.e_r1r = e1; v.e_wen = ew; v.e_waddr = ea; v.e_wdata = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [14:0] a0, input logic [23:0] d0,
                       input logic v1, input logic [14:0] a1, input logic [23:0] d1);
    r0_valid = v0; r0_addr = a0; r0_data = d0;
    r1_valid = v1; r1_addr = a1; r1_data = d1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 15'd0, 24'd0, 1'b0, 15'd0, 24'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n_wr;
    int n_r0;
    int bad_seq;
    int both;
    logic [23:0] exp_d;

    // Rows: each row's expectation is checked first, then the row's inputs are applied.
    // Rows 0-4: r0 writes 3 beats at addresses 0,1,2.
    // Rows 5-8: round-robin. last_owner=0, so r1 wins the tie; r1 then hands off to r0.
    // Rows 9-15: reset restores last_owner=1; r0 wins the tie, drops, and hands off to r1 with no bubble.
    vecs[0]  = mk(1'b0, 1'b1, 15'd0,  24'hFF0000, 1'b0, 15'd0,  24'h000000, 2'd0, 1'b0, 1'b0, 1'b0, 15'd0,  24'h000000);
    vecs[1]  = mk(1'b0, 1'b1, 15'd0,  24'hFF0000, 1'b0, 15'd0,  24'h000000, 2'd1, 1'b1, 1'b0, 1'b0, 15'd0,  24'h000000);
    vecs[2]  = mk(1'b0, 1'b1, 15'd1,  24'hFF0000, 1'b0, 15'd0,  24'h000000, 2'd1, 1'b1, 1'b0, 1'b1, 15'd0,  24'hFF0000);
    vecs[3]  = mk(1'b0, 1'b1, 15'd2,  24'hFF0000, 1'b0, 15'd0,  24'h000000, 2'd1, 1'b1, 1'b0, 1'b1, 15'd1,  24'hFF0000);
    vecs[4]  = mk(1'b0, 1'b0, 15'd0,  24'h000000, 1'b0, 15'd0,  24'h000000, 2'd1, 1'b1, 1'b0, 1'b1, 15'd2,  24'hFF0000);
    vecs[5]  = mk(1'b0, 1'b1, 15'd3,  24'hFF0000, 1'b1, 15'd7,  24'h00FF00, 2'd0, 1'b0, 1'b0, 1'b0, 15'd2,  24'hFF0000);
    vecs[6]  = mk(1'b0, 1'b1, 15'd3,  24'hFF0000, 1'b1, 15'd7,  24'h00FF00, 2'd2, 1'b0, 1'b1, 1'b0, 15'd2,  24'hFF0000);
    vecs[7]  = mk(1'b0, 1'b1, 15'd3,  24'hFF0000, 1'b0, 15'd0,  24'h000000, 2'd2, 1'b0, 1'b1, 1'b1, 15'd7,  24'h00FF00);
    vecs[8]  = mk(1'b0, 1'b0, 15'd0,  24'h000000, 1'b0, 15'd0,  24'h000000, 2'd1, 1'b1, 1'b0, 1'b0, 15'd7,  24'h00FF00);
    vecs[9]  = mk(1'b1, 1'b0, 15'd0,  24'h000000, 1'b0, 15'd0,  24'h000000, 2'd0, 1'b0, 1'b0, 1'b0, 15'd7,  24'h00FF00);
    vecs[10] = mk(1'b0, 1'b1, 15'd10, 24'h0A0A0A, 1'b1, 15'd20, 24'h0B0B0B, 2'd0, 1'b0, 1'b0, 1'b0, 15'd0,  24'h000000);
    vecs[11] = mk(1'b0, 1'b1, 15'd10, 24'h0A0A0A, 1'b1, 15'd20, 24'h0B0B0B, 2'd1, 1'b1, 1'b0, 1'b0, 15'd0,  24'h000000);
    vecs[12] = mk(1'b0, 1'b0, 15'd0,  24'h000000, 1'b1, 15'd20, 24'h0B0B0B, 2'd1, 1'b1, 1'b0, 1'b1, 15'd10, 24'h0A0A0A);
    vecs[13] = mk(1'b0, 1'b0, 15'd0,  24'h000000, 1'b1, 15'd20, 24'h0B0B0B, 2'd2, 1'b0, 1'b1, 1'b0, 15'd10, 24'h0A0A0A);
    vecs[14] = mk(1'b0, 1'b0, 15'd0,  24'h000000, 1'b0, 15'd0,  24'h000000, 2'd2, 1'b0, 1'b1, 1'b1, 15'd20, 24'h0B0B0B);
    vecs[15] = mk(1'b0, 1'b0, 15'd0,  24'h000000, 1'b0, 15'd0,  24'h000000, 2'd0, 1'b0, 1'b0, 1'b0, 15'd20, 24'h0B0B0B);

    // Check the outputs while reset is held.
    @(negedge clk);
    check("reset_state", {owner, r0_ready, r1_ready, wr_en, wr_addr, wr_data, drop_cnt},
          {2'd0, 1'b0, 1'b0, 1'b0, 15'd0, 24'd0, 16'd0});

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d", i), {owner, r0_ready, r1_ready, wr_en, wr_addr, wr_data},
            {vecs[i].e_owner, vecs[i].e_r0r, vecs[i].e_r1r, vecs[i].e_wen, vecs[i].e_waddr, vecs[i].e_wdata});
      rst = vecs[i].rst;
      drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
    end

    // Reset in the middle of a burst: the presented beat 2 must never be written.
    do_reset();
    drive(1'b1, 15'd5, 24'hC0C0C0, 1'b0, 15'd0, 24'd0);
    @(negedge clk);
    check("midrst_grant", {owner, r0_ready}, {2'd1, 1'b1});
    @(negedge clk);
    check("midrst_beat1", {wr_en, wr_addr, wr_data}, {1'b1, 15'd5, 24'hC0C0C0});
    drive(1'b1, 15'd6, 24'hC1C1C1, 1'b0, 15'd0, 24'd0);
    rst = 1'b1;
    #1;
    check("midrst_immediate", {owner, r0_ready, r1_ready, wr_en, wr_addr}, {2'd0, 1'b0, 1'b0, 1'b0, 15'd0});
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 15'd0, 24'd0, 1'b0, 15'd0, 24'd0);
    #1;
    check("midrst_no_beat2", {wr_en, wr_addr, wr_data}, {1'b0, 15'd0, 24'd0});
    @(negedge clk);
    check("midrst_after", {owner, wr_en, wr_addr}, {2'd0, 1'b0, 15'd0});

    // Both requesters stay valid: bursts of 4 beats should alternate between them.
    do_reset();
    drive(1'b1, 15'd100, 24'd1, 1'b1, 15'd200, 24'd2);
    n_wr = 0; n_r0 = 0; bad_seq = 0; both = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (r0_ready && r1_ready) both++;
      if (k >= 2) begin
        if (wr_en) n_wr++;
        if (wr_en && (wr_data == 24'd1)) n_r0++;
        exp_d = ((((k - 2) / 4) % 2) == 0) ? 24'd1 : 24'd2;
        if (!wr_en || (wr_data != exp_d)) bad_seq++;
      end
    end
    drive(1'b0, 15'd0, 24'd0, 1'b0, 15'd0, 24'd0);
    check("rr_total_writes", 64'(n_wr), 64'd32);
    check("rr_r0_share", 64'(n_r0), 64'd16);
    check("rr_alternation", 64'(bad_seq), 64'd0);
    check("rr_both_ready", 64'(both), 64'd0);

    // Address boundary: 19199 is the last valid word and 19200 is the first out-of-range word.
    do_reset();
    drive(1'b0, 15'd0, 24'd0, 1'b1, 15'd19199, 24'h123456);
    @(negedge clk);
    check("range_grant1", {owner, r1_ready, r0_ready}, {2'd2, 1'b1, 1'b0});
    @(negedge clk);
    check("range_last_word", {wr_en, wr_addr, wr_data}, {1'b1, 15'd19199, 24'h123456});
    check("range_ready_beat2", {r1_ready}, {1'b1});
    drive(1'b0, 15'd0, 24'd0, 1'b1, 15'd19200, 24'h654321);
    @(negedge clk);
`ifdef FBWA_ADDR_CHECK_EN
    check("range_dropped", {wr_en, wr_addr, wr_data}, {1'b0, 15'd19199, 24'h123456});
    check("range_drop_cnt", {drop_cnt}, {16'd1});
`else
    check("range_forwarded", {wr_en, wr_addr, wr_data}, {1'b1, 15'd19200, 24'h654321});
    check("range_drop_cnt_tied", {drop_cnt}, {16'd0});
`endif
    drive(1'b0, 15'd0, 24'd0, 1'b0, 15'd0, 24'd0);
    @(negedge clk);
    check("range_idle", {owner, wr_en}, {2'd0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
